// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for shift_add_multiplier.
// The sgn line exists only when SMP_SIGNED_EN is defined.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 4
) ();
  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               clr;
`ifdef SMP_SIGNED_EN
  logic               sgn;
`endif
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               zero;

  modport master (
`ifdef SMP_SIGNED_EN
    output sgn,
`endif
    output start, op_a, op_b, clr,
    input  busy, done, product, zero
  );

  modport slave (
`ifdef SMP_SIGNED_EN
    input  sgn,
`endif
    input  start, op_a, op_b, clr,
    output busy, done, product, zero
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH iterations per product plus DONE.
// Define SMP_SIGNED_EN to add the sgn input and two's-complement operation.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  shift_add_multiplier_if.slave  bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [PW-1:0]   acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic [PW-1:0]   product_reg;
  logic            zero_reg;

  logic            load;
  logic            step;
  logic            finish;
  logic            last_iter;
  logic [PW-1:0]   sum;
  logic [PW-1:0]   final_value;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef SMP_SIGNED_EN
  logic neg_reg;
  logic a_neg;
  logic b_neg;

  // Magnitudes of the most negative value still fit as WIDTH-bit unsigned.
  assign a_neg       = bus.sgn & bus.op_a[WIDTH-1];
  assign b_neg       = bus.sgn & bus.op_b[WIDTH-1];
  assign a_mag       = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag       = b_neg ? -bus.op_b : bus.op_b;
  assign final_value = neg_reg ? -sum : sum;
`else
  assign a_mag       = bus.op_a;
  assign b_mag       = bus.op_b;
  assign final_value = sum;
`endif

  assign sum       = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_RUN;
          load       = 1'b1;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last_iter) begin
          state_next = S_DONE;
          finish     = 1'b1;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg  <= S_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        mcand_reg  <= PW'(a_mag);
        mplier_reg <= b_mag;
        acc_reg    <= '0;
        cnt_reg    <= '0;
      end else if (step) begin
        acc_reg    <= sum;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        if (!last_iter) begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  end

`ifdef SMP_SIGNED_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      neg_reg <= 1'b0;
    end else if (load) begin
      neg_reg <= a_neg ^ b_neg;
    end
  end
`endif

  // A completion on the same edge as clr takes priority over the clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      product_reg <= '0;
      zero_reg    <= 1'b1;
    end else if (finish) begin
      product_reg <= final_value;
      zero_reg    <= (final_value == '0);
    end else if (bus.clr) begin
      product_reg <= '0;
      zero_reg    <= 1'b1;
    end
  end

  assign bus.busy    = (state_reg != S_IDLE);
  assign bus.done    = (state_reg == S_DONE);
  assign bus.product = product_reg;
  assign bus.zero    = zero_reg;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: directed scenarios then random operands.
// Signed scenarios run only when SMP_SIGNED_EN is defined.
module tb_shift_add_multiplier;
  localparam int W  = 4;
  localparam int PW = 2 * W;

  typedef struct {
    logic [PW-1:0] val;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sgn_drv = 1'b0;
  logic sgn_now;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

`ifdef SMP_SIGNED_EN
  assign bus.sgn = sgn_drv;
  assign sgn_now = sgn_drv;
`else
  assign sgn_now = 1'b0;
`endif

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int free_cyc = 0;
  logic [PW-1:0] prod_model = '0;
  exp_t q[$];

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    if (s) begin
      if (a[W-1]) sa = sa - (1 << W);
      if (b[W-1]) sb = sb - (1 << W);
    end
    return PW'(sa * sb);
  endfunction

  function automatic void chk(input string name, input logic [PW-1:0] act,
                              input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
    end
  endfunction

  // Model: acceptance when idle, completion WIDTH edges later, clr loses to completion.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      q.delete();
      free_cyc   = cyc + 1;
      prod_model = '0;
    end else begin
      if (q.size() > 0 && q[0].cyc + W == cyc) prod_model = q[0].val;
      else if (bus.clr) prod_model = '0;
      if (bus.start && cyc >= free_cyc) begin
        q.push_back('{ref_mul(bus.op_a, bus.op_b, sgn_now), cyc});
        free_cyc = cyc + W + 2;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_done;
    if (cyc > 0) begin
      exp_done = (q.size() > 0) && (q[0].cyc + W == cyc);
      chk("busy", PW'(bus.busy), PW'(cyc + 1 < free_cyc));
      chk("done", PW'(bus.done), PW'(exp_done));
      chk("product", bus.product, prod_model);
      chk("zero", PW'(bus.zero), PW'(prod_model == '0));
      if (exp_done) begin
        $display("txn accept=%0d done=%0d product=%h expected=%h",
                 q[0].cyc, cyc, bus.product, q[0].val);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.op_a  = a;
    bus.op_b  = b;
    sgn_drv   = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd_clr);
    repeat (n) begin
      bus.clr = rnd_clr && ($urandom_range(0, 5) == 0);
      @(posedge clk);
      #1;
    end
    bus.clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1, 1'b0);

    issue(4'd15, 4'd15, 1'b0);
    idle(W + 3, 1'b0);
    issue(4'd9, 4'd0, 1'b0);
    idle(W + 3, 1'b0);
    bus.clr = 1'b1;
    idle(1, 1'b0);
    issue(4'd3, 4'd5, 1'b0);
    idle(W + 3, 1'b0);

    // start held through RUN and DONE: only the first IDLE cycle accepts 1x1
    bus.op_a  = 4'd6;
    bus.op_b  = 4'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.op_a = 4'd1;
    bus.op_b = 4'd1;
    repeat (W + 2) @(posedge clk);
    #1 bus.start = 1'b0;
    idle(W + 3, 1'b0);

    issue(4'd13, 4'd11, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2, 1'b0);
    issue(4'd2, 4'd3, 1'b0);
    idle(W + 3, 1'b0);

    issue(4'd5, 4'd5, 1'b0);
    idle(W - 1, 1'b0);
    bus.clr = 1'b1;
    idle(1, 1'b0);
    idle(W, 1'b0);

`ifdef SMP_SIGNED_EN
    issue(4'h8, 4'h7, 1'b1);
    idle(W + 2, 1'b0);
    issue(4'h8, 4'h8, 1'b1);
    idle(W + 2, 1'b0);
    issue(4'h7, 4'hF, 1'b1);
    idle(W + 2, 1'b0);
    issue(4'h8, 4'h7, 1'b0);
    idle(W + 2, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
`ifdef SMP_SIGNED_EN
      issue(W'($urandom), W'($urandom), 1'($urandom));
`else
      issue(W'($urandom), W'($urandom), 1'b0);
`endif
      idle(W + 1 + $urandom_range(0, 2), 1'b1);
    end

    idle(W + 3, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
